ad9914_reg_rd: RTL and testbench
================================

AD9914_REG_RD -- requirements
Module: ad9914_reg_rd

Interface
REQ-001 Parameter ADDR_SETUP, default 2: clk cycles from p_addr valid to p_rd falling; legal range 1..15.
REQ-002 Parameter RD_LOW, default 4: clk cycles p_rd is held low per byte; p_rdata is sampled in the last of these cycles; legal range 1..15.
REQ-003 Parameter RD_RECOVER, default 2: clk cycles p_rd is high after each byte before the next address change; legal range 1..15.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 load  in  1  read request; sampled only in IDLE.
REQ-007 reg_base_addr  in  8  AD9914 register number; bits [5:0] are used.
REQ-008 reg_byte_num  in  4  number of bytes to read; legal values 1..4.
REQ-009 reg_expect  in  32  expected readback value, compared over the bytes read.
REQ-010 reg_rvar  out  32  assembled readback word.
REQ-011 res  out  1  error flag: illegal length or readback mismatch.
REQ-012 busy  out  1  transaction in progress.
REQ-013 finish  out  1  idle/complete indicator.
REQ-014 p_pwd  out  1  bus width select; 0 = 8-bit, driven constant 0.
REQ-015 p_rd  out  1  read strobe, active low.
REQ-016 p_wr  out  1  write strobe, active low; driven constant 1.
REQ-017 p_addr  out  8  byte address.
REQ-018 p_rdata  in  8  read data from the DDS.
REQ-019 data_tri_select  out  1  1 = FPGA data drivers released; driven constant 1.

Function
REQ-020 States: IDLE, SETUP, STROBE, RECOVER, DONE.
REQ-021 IDLE with load=1 and reg_byte_num in 1..4: latch base, length and reg_expect; clear reg_rvar to 0; clear res; go to SETUP.
REQ-022 IDLE with load=1 and reg_byte_num 0 or >4: no bus cycle; go to DONE with res=1 and reg_rvar=0.
REQ-023 Byte k (k = 0..N-1) uses p_addr = {reg_base_addr[5:0],2'b00}+k and is stored in reg_rvar[8k+7:8k]; bytes at or above N stay 0.
REQ-024 SETUP lasts ADDR_SETUP cycles with p_addr valid and p_rd=1.
REQ-025 STROBE lasts RD_LOW cycles with p_rd=0; p_rdata is captured in its final cycle.
REQ-026 RECOVER lasts RD_RECOVER cycles with p_rd=1, then goes to SETUP for the next byte, or to DONE after byte N-1.
REQ-027 p_addr changes only on SETUP entry, never while p_rd=0.
REQ-028 Handshake: busy=1 and finish=0 from the cycle after acceptance (T+1) until completion.
REQ-029 Completion cycle = T+1+N*(ADDR_SETUP+RD_LOW+RD_RECOVER): busy=0, finish=1, reg_rvar and res valid, held until the next acceptance.
REQ-030 res=1 if the bytes read differ from reg_expect in bits [8N-1:0]; upper bits of reg_expect are ignored.
REQ-031 DONE returns to IDLE in one cycle.
REQ-032 load is ignored outside IDLE; the requester drops load on seeing busy=1.
REQ-033 A load still high in IDLE starts a new transaction.
REQ-034 p_rdata is used only in the capture cycle.

Reset
REQ-035 On rst=0, immediately and asynchronously: state=IDLE, busy=0, finish=1, res=0, reg_rvar=0, p_rd=1, p_wr=1, p_addr=0, p_pwd=0, data_tri_select=1.
REQ-036 Reset during STROBE shall deassert p_rd without waiting for RD_LOW to expire; the partial result is discarded.
REQ-037 After rst returns to 1, the block is ready to accept load on the first clk edge.

Structure
REQ-038 Package ad9914_pkg holds: the state enum; register number constants (SFR0..SFR3 = 0x00..0x03, LOWER 0x04, UPPER 0x05, PSTEP 0x06, NSTEP 0x07, RATE 0x08, ASF0 0x0C); default timing constants.
REQ-039 No sub-module; the strobe timing counter (4-bit) and the byte index (2-bit) are inline.

Verification
REQ-040 Bench: responder model of the AD9914 8-bit parallel port, preloaded with a byte-addressed memory; it flags any p_addr change while p_rd=0.
REQ-041 Read 4 bytes of reg 0x01, memory 0x00,0x29,0x04,0x00 at addresses 0x04..0x07, reg_expect 0x00042900 -> reg_rvar=0x00042900, res=0, finish at T+33 with defaults.
REQ-042 Same read with reg_expect 0x00042901 -> reg_rvar=0x00042900, res=1.
REQ-043 reg_byte_num=2, reg 0x0C, memory 0x00,0x00,0xFF,0x0F -> reg_rvar=0x00000000, exactly 2 p_rd pulses, finish at T+17.
REQ-044 reg_byte_num=0, then reg_byte_num=5 -> no p_rd pulse, res=1, finish at T+2.
REQ-045 rst=0 asserted during the 3rd STROBE -> p_rd=1 in the same cycle and all outputs at reset values; a following 4-byte read completes correctly.
REQ-046 load held high through completion -> a second transaction starts in the cycle after the return to IDLE; no load pulse is accepted while busy=1.

Source files
------------

// File: rtl/ad9914_pkg.sv
// Shared types and constants for the AD9914 parallel-port register reader.
package ad9914_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      STROBE  = 3'd2,
      RECOVER = 3'd3,
      DONE    = 3'd4
   } state_e;

   localparam logic [7:0] REG_SFR0  = 8'h00;
   localparam logic [7:0] REG_SFR1  = 8'h01;
   localparam logic [7:0] REG_SFR2  = 8'h02;
   localparam logic [7:0] REG_SFR3  = 8'h03;
   localparam logic [7:0] REG_LOWER = 8'h04;
   localparam logic [7:0] REG_UPPER = 8'h05;
   localparam logic [7:0] REG_PSTEP = 8'h06;
   localparam logic [7:0] REG_NSTEP = 8'h07;
   localparam logic [7:0] REG_RATE  = 8'h08;
   localparam logic [7:0] REG_ASF0  = 8'h0C;

   localparam int unsigned ADDR_SETUP_DEF = 2;
   localparam int unsigned RD_LOW_DEF     = 4;
   localparam int unsigned RD_RECOVER_DEF = 2;

   localparam int unsigned CNT_W = 4;
   localparam int unsigned IDX_W = 2;

endpackage

// File: rtl/ad9914_reg_rd.sv
// Reads a 1..4 byte AD9914 register over the 8-bit parallel port and
// compares the assembled word against an expected value.
module ad9914_reg_rd
   import ad9914_pkg::*;
#(
   parameter int unsigned ADDR_SETUP = ADDR_SETUP_DEF,
   parameter int unsigned RD_LOW     = RD_LOW_DEF,
   parameter int unsigned RD_RECOVER = RD_RECOVER_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [7:0]  reg_base_addr,
   input  logic [3:0]  reg_byte_num,
   input  logic [31:0] reg_expect,
   output logic [31:0] reg_rvar,
   output logic        res,
   output logic        busy,
   output logic        finish,
   output logic        p_pwd,
   output logic        p_rd,
   output logic        p_wr,
   output logic [7:0]  p_addr,
   input  logic [7:0]  p_rdata,
   output logic        data_tri_select
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   r_last;
   logic [5:0]         r_base;
   logic [31:0]        r_expect;
   logic               r_bad;

   logic               w_len_ok;
   logic               w_accept;
   logic               w_cnt_done;
   logic               w_last_byte;
   logic [31:0]        w_mask;
   logic [31:0]        w_rvar_nxt;
   logic               w_res_nxt;
   logic               w_busy_nxt;
   logic               w_rd_nxt;
   logic [7:0]         w_addr_nxt;
   logic               w_unused;

   assign w_len_ok    = (reg_byte_num != 4'd0) && (reg_byte_num <= 4'd4);
   assign w_accept    = (r_state == IDLE) && load;
   // An illegal length drains through a single RECOVER cycle with no strobe.
   assign w_last_byte = r_bad || (r_idx == r_last);
   assign w_mask      = 32'hFFFF_FFFF >> {2'd3 - r_last, 3'b000};
   assign w_unused    = ^reg_base_addr[7:6];

   assign p_pwd           = 1'b0;
   assign p_wr            = 1'b1;
   assign data_tri_select = 1'b1;

   always_comb begin
      w_cnt_done = 1'b0;
      case (r_state)
         SETUP:   w_cnt_done = (r_cnt == CNT_W'(ADDR_SETUP - 1));
         STROBE:  w_cnt_done = (r_cnt == CNT_W'(RD_LOW - 1));
         RECOVER: w_cnt_done = r_bad || (r_cnt == CNT_W'(RD_RECOVER - 1));
         default: w_cnt_done = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (load) w_state_nxt = w_len_ok ? SETUP : RECOVER;
         SETUP:   if (w_cnt_done) w_state_nxt = STROBE;
         STROBE:  if (w_cnt_done) w_state_nxt = RECOVER;
         RECOVER: if (w_cnt_done) w_state_nxt = w_last_byte ? DONE : SETUP;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output next-values, registered below so they line up with the new state
   always_comb begin
      w_busy_nxt = (w_state_nxt == SETUP) || (w_state_nxt == STROBE) ||
                   (w_state_nxt == RECOVER);
      w_rd_nxt   = (w_state_nxt != STROBE);
      w_addr_nxt = p_addr;
      w_rvar_nxt = reg_rvar;
      w_res_nxt  = res;
      case (r_state)
         IDLE: begin
            if (load) begin
               w_rvar_nxt = '0;
               w_res_nxt  = !w_len_ok;
               if (w_len_ok) w_addr_nxt = {reg_base_addr[5:0], 2'b00};
            end
         end
         STROBE: begin
            if (w_cnt_done) w_rvar_nxt[{r_idx, 3'b000} +: 8] = p_rdata;
         end
         RECOVER: begin
            if (w_cnt_done) begin
               if (!w_last_byte)
                  w_addr_nxt = {r_base, r_idx + IDX_W'(1)};
               else if (!r_bad)
                  w_res_nxt = |((reg_rvar ^ r_expect) & w_mask);
            end
         end
         default: ;
      endcase
   end

   // Strobe timing counter, byte index and latched request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt    <= '0;
         r_idx    <= '0;
         r_last   <= '0;
         r_base   <= '0;
         r_expect <= '0;
         r_bad    <= 1'b0;
      end else begin
         r_cnt <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
         if (w_accept) begin
            r_base   <= reg_base_addr[5:0];
            r_last   <= IDX_W'(reg_byte_num - 4'd1);
            r_expect <= reg_expect;
            r_bad    <= !w_len_ok;
            r_idx    <= '0;
         end else if ((r_state == RECOVER) && w_cnt_done && !w_last_byte) begin
            r_idx <= r_idx + IDX_W'(1);
         end
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy     <= 1'b0;
         finish   <= 1'b1;
         res      <= 1'b0;
         reg_rvar <= '0;
         p_rd     <= 1'b1;
         p_addr   <= '0;
      end else begin
         busy     <= w_busy_nxt;
         finish   <= !w_busy_nxt;
         res      <= w_res_nxt;
         reg_rvar <= w_rvar_nxt;
         p_rd     <= w_rd_nxt;
         p_addr   <= w_addr_nxt;
      end
   end

endmodule

// File: tb/tb_ad9914_reg_rd.sv
// Bench for ad9914_reg_rd: AD9914 parallel-port responder with a byte memory,
// directed scenarios plus randomized reads against a behavioural model.
module tb_ad9914_reg_rd;

   localparam int unsigned AS = 2;
   localparam int unsigned RL = 4;
   localparam int unsigned RR = 2;

   logic        clk;
   logic        rst;
   logic        load;
   logic [7:0]  reg_base_addr;
   logic [3:0]  reg_byte_num;
   logic [31:0] reg_expect;
   logic [31:0] reg_rvar;
   logic        res;
   logic        busy;
   logic        finish;
   logic        p_pwd;
   logic        p_rd;
   logic        p_wr;
   logic [7:0]  p_addr;
   logic [7:0]  p_rdata;
   logic        data_tri_select;

   logic [7:0]  mem [256];
   int          lowcnt = 0;
   int          pulses = 0;
   int          viol = 0;
   logic        prev_rd = 1'b1;
   logic [7:0]  prev_addr = 8'h00;
   int          n_checks = 0;
   int          n_pass = 0;

   ad9914_reg_rd #(.ADDR_SETUP(AS), .RD_LOW(RL), .RD_RECOVER(RR)) dut (
      .clk(clk), .rst(rst), .load(load), .reg_base_addr(reg_base_addr),
      .reg_byte_num(reg_byte_num), .reg_expect(reg_expect), .reg_rvar(reg_rvar),
      .res(res), .busy(busy), .finish(finish), .p_pwd(p_pwd), .p_rd(p_rd),
      .p_wr(p_wr), .p_addr(p_addr), .p_rdata(p_rdata),
      .data_tri_select(data_tri_select)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Responder: data is only valid in the last cycle of the low phase
   always @(posedge clk) lowcnt <= (p_rd === 1'b0) ? lowcnt + 1 : 0;
   assign p_rdata = (p_rd === 1'b0 && lowcnt == int'(RL) - 1) ? mem[p_addr] : 8'hEE;

   // Bus monitor: count strobes, flag address changes while p_rd is low
   always @(negedge clk) begin
      if (prev_rd === 1'b1 && p_rd === 1'b0) pulses <= pulses + 1;
      if (prev_rd === 1'b0 && p_rd === 1'b0 && p_addr !== prev_addr) viol <= viol + 1;
      prev_rd   <= p_rd;
      prev_addr <= p_addr;
   end

   function automatic logic [31:0] model_rvar(logic [7:0] base, int n);
      logic [31:0] v;
      v = 32'h0;
      if (n >= 1 && n <= 4)
         for (int k = 0; k < n; k++)
            v = v | (32'(mem[(int'(base) % 64) * 4 + k]) << (8 * k));
      return v;
   endfunction

   function automatic logic model_res(logic [31:0] rv, logic [31:0] ev, int n);
      logic [63:0] m;
      if (n < 1 || n > 4) return 1'b1;
      m = (64'd1 << (8 * n)) - 64'd1;
      return (({32'd0, rv} & m) != ({32'd0, ev} & m));
   endfunction

   function automatic int model_k(int n);
      return (n >= 1 && n <= 4) ? 1 + n * int'(AS + RL + RR) : 2;
   endfunction

   // Issue one request and report what the DUT produced
   task automatic do_read(input logic [7:0] base, input logic [3:0] n,
                          input logic [31:0] expv, output logic [31:0] o_rvar,
                          output logic o_res, output int o_k, output int o_pulses,
                          output int o_hs_err);
      int p0;
      @(negedge clk);
      p0 = pulses;
      reg_base_addr = base;
      reg_byte_num  = n;
      reg_expect    = expv;
      load          = 1'b1;
      o_k      = -1;
      o_hs_err = 0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (busy === 1'b1) load = 1'b0;
         if (finish === 1'b1) begin
            o_k = k;
            break;
         end
         if (busy !== 1'b1) o_hs_err++;
      end
      load   = 1'b0;
      o_rvar = reg_rvar;
      o_res  = res;
      @(negedge clk);
      o_pulses = pulses - p0;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b0;
      reg_base_addr = '0; reg_byte_num = '0; reg_expect = '0;
      #3 rst = 1'b0;
      #1;
      n_checks++;
      if ({busy, finish, res, p_rd, p_wr, p_pwd, data_tri_select} !== 7'b0101101)
         $display("FAIL reset_ctrl got %b want 0101101",
                  {busy, finish, res, p_rd, p_wr, p_pwd, data_tri_select});
      else n_pass++;
      n_checks++;
      if (reg_rvar !== 32'h0) $display("FAIL reset_rvar got %h want 0", reg_rvar);
      else n_pass++;
      n_checks++;
      if (p_addr !== 8'h00) $display("FAIL reset_addr got %h want 00", p_addr);
      else n_pass++;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_read_match();
      logic [31:0] rv; logic rs; int k, np, hs;
      mem[4] = 8'h00; mem[5] = 8'h29; mem[6] = 8'h04; mem[7] = 8'h00;
      do_read(8'h01, 4'd4, 32'h0004_2900, rv, rs, k, np, hs);
      n_checks++; if (rv !== 32'h0004_2900) $display("FAIL match_rvar got %h want 00042900", rv); else n_pass++;
      n_checks++; if (rs !== 1'b0) $display("FAIL match_res got %b want 0", rs); else n_pass++;
      n_checks++; if (k != 33) $display("FAIL match_latency got %0d want 33", k); else n_pass++;
      n_checks++; if (np != 4) $display("FAIL match_pulses got %0d want 4", np); else n_pass++;
      n_checks++; if (hs != 0) $display("FAIL match_handshake got %0d bad cycles want 0", hs); else n_pass++;
   endtask

   task automatic test_read_mismatch();
      logic [31:0] rv; logic rs; int k, np, hs;
      do_read(8'h01, 4'd4, 32'h0004_2901, rv, rs, k, np, hs);
      n_checks++; if (rv !== 32'h0004_2900) $display("FAIL mismatch_rvar got %h want 00042900", rv); else n_pass++;
      n_checks++; if (rs !== 1'b1) $display("FAIL mismatch_res got %b want 1", rs); else n_pass++;
      n_checks++; if (k != 33) $display("FAIL mismatch_latency got %0d want 33", k); else n_pass++;
   endtask

   task automatic test_bad_length();
      logic [31:0] rv; logic rs; int k, np, hs;
      logic [3:0] lens [2];
      lens[0] = 4'd0; lens[1] = 4'd5;
      for (int i = 0; i < 2; i++) begin
         do_read(8'h01, lens[i], 32'h0004_2900, rv, rs, k, np, hs);
         n_checks++; if (rv !== 32'h0) $display("FAIL badlen%0d_rvar got %h want 0", lens[i], rv); else n_pass++;
         n_checks++; if (rs !== 1'b1) $display("FAIL badlen%0d_res got %b want 1", lens[i], rs); else n_pass++;
         n_checks++; if (k != 2) $display("FAIL badlen%0d_latency got %0d want 2", lens[i], k); else n_pass++;
         n_checks++; if (np != 0) $display("FAIL badlen%0d_pulses got %0d want 0", lens[i], np); else n_pass++;
      end
   endtask

   task automatic test_two_bytes();
      logic [31:0] rv; logic rs; int k, np, hs;
      mem[8'h30] = 8'h00; mem[8'h31] = 8'h00; mem[8'h32] = 8'hFF; mem[8'h33] = 8'h0F;
      do_read(8'h0C, 4'd2, 32'hFFFF_0000, rv, rs, k, np, hs);
      n_checks++; if (rv !== 32'h0) $display("FAIL two_rvar got %h want 0", rv); else n_pass++;
      n_checks++; if (rs !== 1'b0) $display("FAIL two_res got %b want 0", rs); else n_pass++;
      n_checks++; if (k != 17) $display("FAIL two_latency got %0d want 17", k); else n_pass++;
      n_checks++; if (np != 2) $display("FAIL two_pulses got %0d want 2", np); else n_pass++;
   endtask

   task automatic test_reset_in_strobe();
      logic [31:0] rv; logic rs; int k, np, hs, cnt;
      logic prv;
      @(negedge clk);
      reg_base_addr = 8'h01; reg_byte_num = 4'd4; reg_expect = 32'h0004_2900; load = 1'b1;
      cnt = 0; prv = 1'b1;
      for (int i = 0; i < 200 && cnt < 3; i++) begin
         @(negedge clk);
         if (busy === 1'b1) load = 1'b0;
         if (prv === 1'b1 && p_rd === 1'b0) cnt++;
         prv = p_rd;
      end
      load = 1'b0;
      n_checks++; if (cnt != 3) $display("FAIL rststb_reach got %0d strobes want 3", cnt); else n_pass++;
      #1 rst = 1'b0;
      #1;
      n_checks++; if (p_rd !== 1'b1) $display("FAIL rststb_prd got %b want 1", p_rd); else n_pass++;
      n_checks++;
      if ({busy, finish, res, p_wr, p_pwd, data_tri_select} !== 6'b010101)
         $display("FAIL rststb_ctrl got %b want 010101", {busy, finish, res, p_wr, p_pwd, data_tri_select});
      else n_pass++;
      n_checks++;
      if (reg_rvar !== 32'h0 || p_addr !== 8'h00)
         $display("FAIL rststb_data got rvar=%h addr=%h want 0/00", reg_rvar, p_addr);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      do_read(8'h01, 4'd4, 32'h0004_2900, rv, rs, k, np, hs);
      n_checks++; if (rv !== 32'h0004_2900) $display("FAIL rststb_after_rvar got %h want 00042900", rv); else n_pass++;
      n_checks++; if (rs !== 1'b0) $display("FAIL rststb_after_res got %b want 0", rs); else n_pass++;
      n_checks++; if (k != 33) $display("FAIL rststb_after_latency got %0d want 33", k); else n_pass++;
   endtask

   task automatic test_load_held();
      logic [7:0] base; logic [31:0] ev; int k1, c, p0;
      base = 8'($urandom);
      ev   = model_rvar(base, 2);
      @(negedge clk);
      p0 = pulses;
      reg_base_addr = base; reg_byte_num = 4'd2; reg_expect = ev; load = 1'b1;
      k1 = -1;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (finish === 1'b1) begin k1 = k; break; end
      end
      n_checks++; if (k1 != 17) $display("FAIL held_first_latency got %0d want 17", k1); else n_pass++;
      @(negedge clk);
      n_checks++; if ({busy, finish} !== 2'b01) $display("FAIL held_idle got busy/finish %b want 01", {busy, finish}); else n_pass++;
      @(negedge clk);
      n_checks++; if ({busy, finish} !== 2'b10) $display("FAIL held_restart got busy/finish %b want 10", {busy, finish}); else n_pass++;
      c = 1;
      for (int k = 2; k <= 200; k++) begin
         @(negedge clk);
         load = (k < 10) ? 1'(k % 2) : 1'b0;
         if (finish === 1'b1) begin c = k; break; end
      end
      load = 1'b0;
      n_checks++; if (c != 17) $display("FAIL held_second_latency got %0d want 17", c); else n_pass++;
      n_checks++; if (reg_rvar !== ev || res !== 1'b0) $display("FAIL held_result got %h/%b want %h/0", reg_rvar, res, ev); else n_pass++;
      @(negedge clk);
      n_checks++; if (pulses - p0 != 4) $display("FAIL held_pulses got %0d want 4", pulses - p0); else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] rv, ev, want; logic rs; int k, np, hs, n;
      logic [7:0] base;
      logic [63:0] lowm;
      for (int it = 0; it < 24; it++) begin
         n = $urandom_range(0, 6);
         if ($urandom_range(0, 3) != 0) n = $urandom_range(1, 4);
         base = 8'($urandom);
         want = model_rvar(base, n);
         lowm = (n >= 1 && n <= 4) ? (64'd1 << (8 * n)) - 64'd1 : 64'd0;
         ev   = (want & lowm[31:0]) | (32'($urandom) & ~lowm[31:0]);
         if ($urandom_range(0, 1) == 1) ev = ev ^ (32'd1 << $urandom_range(0, 31));
         do_read(base, 4'(n), ev, rv, rs, k, np, hs);
         n_checks++; if (rv !== want) $display("FAIL rnd%0d_rvar got %h want %h", it, rv, want); else n_pass++;
         n_checks++; if (rs !== model_res(want, ev, n)) $display("FAIL rnd%0d_res got %b want %b", it, rs, model_res(want, ev, n)); else n_pass++;
         n_checks++; if (k != model_k(n)) $display("FAIL rnd%0d_latency got %0d want %0d", it, k, model_k(n)); else n_pass++;
         n_checks++; if (np != ((n >= 1 && n <= 4) ? n : 0)) $display("FAIL rnd%0d_pulses got %0d want %0d", it, np, (n >= 1 && n <= 4) ? n : 0); else n_pass++;
         n_checks++; if (hs != 0) $display("FAIL rnd%0d_handshake got %0d bad cycles want 0", it, hs); else n_pass++;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      test_reset();
      test_read_match();
      test_read_mismatch();
      test_bad_length();
      test_two_bytes();
      test_reset_in_strobe();
      test_load_held();
      test_random();
      n_checks++;
      if (viol != 0) $display("FAIL addr_stable got %0d changes while p_rd low want 0", viol);
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
